// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, fetch FSM states, default widths.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned INSTR_W_DEF = 16;

    localparam logic [3:0] OP_ALU_MIN = 4'b0000;
    localparam logic [3:0] OP_ALU_MAX = 4'b1001;
    localparam logic [3:0] OP_JMP     = 4'b1100;
    localparam logic [3:0] OP_JNZ     = 4'b1101;
    localparam logic [3:0] OP_JZ      = 4'b1110;
    localparam logic [3:0] OP_HALT    = 4'b1111;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        ISSUE = 2'b01,
        HALT  = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Sequential fetch/issue front end: owns the PC, fetches over req/ready, issues to decode.
// Optional FETCH_HALT_EN adds a HALT state entered on opcode 4'b1111.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter int unsigned       INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ready,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               stall,
    input  logic               jmp_enable,
    output logic               instr_valid,
    output logic [3:0]         opcode,
    output logic [INSTR_W-5:0] operand,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               halted
);

    fetch_state_t       state;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  pc_next;
    logic               is_halt_op;

    assign is_halt_op = (ir[INSTR_W-1 -: 4] == OP_HALT);

    always_comb begin
        pc_next = pc + ADDR_W'(1);
        if (jmp_enable) begin
            pc_next = ir[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
`ifdef FETCH_HALT_EN
                        if (is_halt_op) begin
                            state <= HALT;
                        end else begin
                            pc    <= pc_next;
                            state <= FETCH;
                        end
`else
                        pc    <= pc_next;
                        state <= FETCH;
`endif
                    end
                end
`ifdef FETCH_HALT_EN
                HALT: state <= HALT;
`endif
                default: state <= FETCH;
            endcase
        end
    end

    // Outputs are masked while rst is high so the reset cycle itself shows reset values.
    assign mem_req     = !rst && (state == FETCH);
    assign instr_valid = !rst && (state == ISSUE);
    assign mem_addr    = pc;
    assign pc_out      = pc;
    assign opcode      = ir[INSTR_W-1 -: 4];
    assign operand     = ir[INSTR_W-5:0];

`ifdef FETCH_HALT_EN
    assign halted = !rst && (state == HALT);
`else
    assign halted = 1'b0;
    logic unused_halt;
    assign unused_halt = is_halt_op;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed vector bench for instr_fetch_unit; expectations follow FETCH_HALT_EN if defined.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic        stall;
    logic        jmp_enable;
    logic        instr_valid;
    logic [3:0]  opcode;
    logic [11:0] operand;
    logic [7:0]  pc_out;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .stall       (stall),
        .jmp_enable  (jmp_enable),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .operand     (operand),
        .pc_out      (pc_out),
        .halted      (halted)
    );

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [15:0] rdata;
        logic        stall;
        logic        jmp;
        logic        req;
        logic [7:0]  addr;
        logic        iv;
        logic [3:0]  op;
        logic [11:0] opnd;
        logic [7:0]  pc;
        logic        h;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic rdy, logic [15:0] rd, logic st, logic j,
                                logic req, logic [7:0] a, logic iv, logic [3:0] op,
                                logic [11:0] opnd, logic [7:0] pc, logic h);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.rdata = rd; v.stall = st; v.jmp = j;
        v.req = req; v.addr = a; v.iv = iv; v.op = op; v.opnd = opnd; v.pc = pc; v.h = h;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic [15:0] rd,
                         input logic st, input logic j);
        rst = r; mem_ready = rdy; mem_rdata = rd; stall = st; jmp_enable = j;
    endtask

    initial begin
        //            rst rdy rdata    st jmp | req addr  iv op    opnd    pc     h
        tbl.push_back(mk(1, 1, 16'hFFFF, 0, 0, 0, 8'h00, 0, 4'h0, 12'h000, 8'h00, 0));
        tbl.push_back(mk(0, 1, 16'h1234, 0, 0, 1, 8'h00, 0, 4'h0, 12'h000, 8'h00, 0));
        tbl.push_back(mk(0, 1, 16'hFFFF, 0, 0, 0, 8'h00, 1, 4'h1, 12'h234, 8'h00, 0));
        tbl.push_back(mk(0, 1, 16'hC0A5, 0, 0, 1, 8'h01, 0, 4'h1, 12'h234, 8'h01, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 8'h01, 1, 4'hC, 12'h0A5, 8'h01, 0));
        tbl.push_back(mk(0, 1, 16'hC0FF, 0, 0, 1, 8'hA5, 0, 4'hC, 12'h0A5, 8'hA5, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 8'hA5, 1, 4'hC, 12'h0FF, 8'hA5, 0));
        tbl.push_back(mk(0, 1, 16'hC0FF, 0, 0, 1, 8'hA6, 0, 4'hC, 12'h0FF, 8'hA6, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 8'hA6, 1, 4'hC, 12'h0FF, 8'hA6, 0));
        tbl.push_back(mk(0, 1, 16'h2000, 0, 0, 1, 8'hFF, 0, 4'hC, 12'h0FF, 8'hFF, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 8'hFF, 1, 4'h2, 12'h000, 8'hFF, 0));
        // PC wrapped to 0x00; three wait cycles then ready
        tbl.push_back(mk(0, 0, 16'h3111, 0, 0, 1, 8'h00, 0, 4'h2, 12'h000, 8'h00, 0));
        tbl.push_back(mk(0, 0, 16'h3111, 0, 1, 1, 8'h00, 0, 4'h2, 12'h000, 8'h00, 0));
        tbl.push_back(mk(0, 0, 16'h3111, 0, 0, 1, 8'h00, 0, 4'h2, 12'h000, 8'h00, 0));
        tbl.push_back(mk(0, 1, 16'h3111, 0, 0, 1, 8'h00, 0, 4'h2, 12'h000, 8'h00, 0));
        // stall with jmp toggling and a stray mem_ready
        tbl.push_back(mk(0, 1, 16'hFFFF, 1, 1, 0, 8'h00, 1, 4'h3, 12'h111, 8'h00, 0));
        tbl.push_back(mk(0, 1, 16'hFFFF, 1, 0, 0, 8'h00, 1, 4'h3, 12'h111, 8'h00, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 1, 0, 8'h00, 1, 4'h3, 12'h111, 8'h00, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 8'h00, 1, 4'h3, 12'h111, 8'h00, 0));
        // reset coincident with mem_ready in FETCH
        tbl.push_back(mk(1, 1, 16'hABCD, 0, 0, 0, 8'h01, 0, 4'h3, 12'h111, 8'h01, 0));
        tbl.push_back(mk(0, 0, 16'hABCD, 0, 0, 1, 8'h00, 0, 4'h0, 12'h000, 8'h00, 0));
        tbl.push_back(mk(0, 1, 16'hF00F, 0, 0, 1, 8'h00, 0, 4'h0, 12'h000, 8'h00, 0));
`ifdef FETCH_HALT_EN
        tbl.push_back(mk(0, 0, 16'h0000, 0, 1, 0, 8'h00, 1, 4'hF, 12'h00F, 8'h00, 0));
        tbl.push_back(mk(0, 1, 16'h1000, 0, 0, 0, 8'h00, 0, 4'hF, 12'h00F, 8'h00, 1));
        tbl.push_back(mk(0, 1, 16'h1000, 0, 0, 0, 8'h00, 0, 4'hF, 12'h00F, 8'h00, 1));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 8'h00, 0, 4'hF, 12'h00F, 8'h00, 0));
`else
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 8'h00, 1, 4'hF, 12'h00F, 8'h00, 0));
        tbl.push_back(mk(0, 1, 16'h1000, 0, 0, 1, 8'h01, 0, 4'hF, 12'h00F, 8'h01, 0));
        tbl.push_back(mk(0, 1, 16'h1000, 0, 0, 0, 8'h01, 1, 4'h1, 12'h000, 8'h01, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 0, 8'h02, 0, 4'h1, 12'h000, 8'h02, 0));
`endif
        tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 1, 8'h00, 0, 4'h0, 12'h000, 8'h00, 0));

        drive(1, 0, 16'h0000, 0, 0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].rdata, tbl[i].stall, tbl[i].jmp);
            #1;
            chk("mem_req",     i, 32'(mem_req),     32'(tbl[i].req));
            chk("mem_addr",    i, 32'(mem_addr),    32'(tbl[i].addr));
            chk("instr_valid", i, 32'(instr_valid), 32'(tbl[i].iv));
            chk("opcode",      i, 32'(opcode),      32'(tbl[i].op));
            chk("operand",     i, 32'(operand),     32'(tbl[i].opnd));
            chk("pc_out",      i, 32'(pc_out),      32'(tbl[i].pc));
            chk("halted",      i, 32'(halted),      32'(tbl[i].h));
        end

        // Jump-to-self at 0x00 loops with a strict FETCH/ISSUE cadence.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive(0, 1, 16'hC000, 0, 1);
            #1;
            chk("self_req",   k, 32'(mem_req),     32'((k % 2) == 0));
            chk("self_valid", k, 32'(instr_valid), 32'((k % 2) == 1));
            chk("self_addr",  k, 32'(mem_addr),    32'h00);
        end

        // Issue the 0xF word from a fresh reset and watch for halt within a bounded window.
        @(negedge clk);
        drive(1, 0, 16'h0000, 0, 0);
        @(negedge clk);
        drive(0, 1, 16'hF123, 0, 1);
        begin
            int waited;
            waited = 0;
`ifdef FETCH_HALT_EN
            while (!halted && waited < 10) begin
                @(negedge clk);
                waited++;
                #1;
            end
            chk("halt_seen", 0, 32'(halted), 32'd1);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                #1;
                chk("halt_req",  k, 32'(mem_req),     32'd0);
                chk("halt_pc",   k, 32'(pc_out),      32'h00);
                chk("halt_iv",   k, 32'(instr_valid), 32'd0);
            end
`else
            jmp_enable = 0;
            while (!instr_valid && waited < 10) begin
                @(negedge clk);
                waited++;
                #1;
            end
            chk("f_issued", 0, 32'(instr_valid), 32'd1);
            @(negedge clk);
            #1;
            chk("f_next_addr", 0, 32'(mem_addr), 32'h01);
            chk("f_halted",    0, 32'(halted),   32'd0);
            chk("f_req",       0, 32'(mem_req),  32'd1);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Sequential instruction fetch/issue front end for the 8-bit CPU.
- Owns the program counter and fetches 16-bit instruction words from instruction memory over a req/ready handshake.
- Presents the opcode and operand to the decode/control stage.
- Consumes that stage's jump decision to select the next PC: branch target or sequential.

Parameters:
ADDR_W, 8, program counter and instruction memory address width
INSTR_W, 16, instruction word width; opcode = [INSTR_W-1:INSTR_W-4], must satisfy INSTR_W-4 >= ADDR_W
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
mem_req  output  1  instruction read request
mem_addr  output  ADDR_W  read address, equals current PC
mem_ready  input  1  read data valid this cycle, qualified by mem_req
mem_rdata  input  INSTR_W  instruction word
stall  input  1  downstream hold; freezes ISSUE
jmp_enable  input  1  jump decision from control stage for the issued instruction
instr_valid  output  1  opcode/operand valid to decode
opcode  output  4  instruction register [INSTR_W-1:INSTR_W-4]
operand  output  INSTR_W-4  instruction register low bits; jump target = operand[ADDR_W-1:0]
pc_out  output  ADDR_W  PC of the issued instruction
halted  output  1  core halted (only with FETCH_HALT_EN; tied 0 otherwise)

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high. All state updates on the rising edge of clk.
- States: FETCH, ISSUE, HALT. HALT exists only with FETCH_HALT_EN.
- Reset values:
  - state=FETCH, pc=RESET_PC, ir=0
  - mem_req=0 during the reset cycle; asserted the cycle after rst deasserts
  - instr_valid=0, halted=0
  - pc_out=RESET_PC
- FETCH:
  - mem_req=1 and mem_addr=pc.
  - If mem_ready=1 on the edge: ir<=mem_rdata, move to ISSUE.
  - Otherwise stay in FETCH with req and addr held stable. Unbounded wait.
  - mem_ready while mem_req=0 is ignored.
- ISSUE:
  - instr_valid=1, mem_req=0; opcode/operand come from ir; pc_out=pc.
  - If stall=1: remain in ISSUE; ir and pc frozen; jmp_enable ignored.
  - If stall=0 and jmp_enable=1: pc<=operand[ADDR_W-1:0], then FETCH.
  - If stall=0 and jmp_enable=0: pc<=pc+1 modulo 2^ADDR_W (0xFF wraps to 0x00), then FETCH.
- jmp_enable is sampled only in ISSUE with stall=0. It is combinational from opcode in the control stage, so it is valid the same cycle.
- Throughput: 2 cycles per instruction with zero-wait memory; +1 cycle per memory wait cycle; +1 cycle per stall cycle.
- Reset mid-operation:
  - rst in any state returns to the reset values on that edge, even during a pending fetch.
  - A pending mem_ready coincident with rst is discarded.
- Jump to self (target == pc) is legal and loops forever.
- Non-jump opcodes rely on the control stage driving jmp_enable=0. The fetch unit does no opcode decode except HALT.

Optional Feature:
Macro FETCH_HALT_EN.
- Defined:
  - In ISSUE with stall=0 and opcode==4'b1111: enter HALT. pc is not incremented.
  - In HALT: mem_req=0, instr_valid=0, halted=1. Only rst exits HALT.
  - jmp_enable is ignored on the halting instruction.
- Not defined:
  - 4'b1111 is treated as an ordinary non-jump instruction (pc+1).
  - HALT state is absent and halted is tied 0.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_JMP=4'b1100, OP_JNZ=4'b1101, OP_JZ=4'b1110, OP_HALT=4'b1111
  - ALU opcode range 4'b0000-4'b1001
  - fetch state enum (FETCH, ISSUE, HALT)
  - default ADDR_W/INSTR_W
- No sub-module is required. The PC register plus incrementer stays inline.

Test Plan:
1. Reset then zero-wait memory, mem_rdata=0x1234 at addr 0, jmp_enable=0 -> mem_addr 0x00; ISSUE opcode=0x1, operand=0x234, pc_out=0x00; next fetch addr 0x01; 2 cycles/instruction.
2. ISSUE with opcode=0xC, operand=0x0A5, jmp_enable=1 -> next mem_addr=0xA5; with jmp_enable=0 instead -> next mem_addr=pc+1.
3. PC at 0xFF, non-jump -> next mem_addr=0x00 (wrap); then mem_ready low for 3 cycles -> mem_req held 1 and addr 0x00 stable, ISSUE entered on the 4th edge.
4. stall=1 for 2 cycles in ISSUE with jmp_enable toggling -> instr_valid stays 1, opcode/pc_out stable, no PC change; release with jmp_enable=0 -> pc+1.
5. rst asserted in FETCH coincident with mem_ready=1 -> rdata discarded, pc=RESET_PC, instr_valid=0, fetch restarts at 0x00.
6. FETCH_HALT_EN defined, opcode=0xF issued -> halted=1, mem_req=0 indefinitely until rst. Macro undefined, same word -> pc+1, halted=0.
